// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count-based status flags.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   winc/wdata write request and data; accepted only when not full
//   wfull      occupancy == DEPTH
//   awfull     occupancy >= DEPTH-ALMOST
//   overflow   one-cycle pulse after a write requested while full
//   rinc       read request (pop); accepted only when not empty
//   rdata      read data (fall-through or registered, see FALLTHROUGH)
//   rempty     occupancy == 0
//   arempty    occupancy <= ALMOST
//   underflow  one-cycle pulse after a read requested while empty
//   count      current occupancy, 0..DEPTH
//
// All flags are registered from the next occupancy, so they describe the
// FIFO as it stands after the current edge.

module sync_fifo #(
    parameter int DSIZE       = 8,
    parameter int ASIZE       = 4,
    parameter     FALLTHROUGH = "TRUE",
    parameter int ALMOST      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    output logic             overflow,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty,
    output logic             underflow,
    output logic [ASIZE:0]   count
);

    localparam int             DEPTH     = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C   = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_TH  = (ASIZE+1)'(DEPTH - ALMOST);
    localparam logic [ASIZE:0] AEMPTY_TH = (ASIZE+1)'(ALMOST);

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic [ASIZE:0] count_q, count_d;
    logic           wfull_q, wfull_d;
    logic           awfull_q, awfull_d;
    logic           rempty_q, rempty_d;
    logic           arempty_q, arempty_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    logic w_acc;
    logic r_acc;

    // Acceptance is judged against the registered flags, so on a full FIFO a
    // simultaneous read frees a slot only for the following cycle.
    assign w_acc = winc & ~wfull_q;
    assign r_acc = rinc & ~rempty_q;

    always_comb begin
        wptr_d      = wptr_q + {{ASIZE{1'b0}}, w_acc};
        rptr_d      = rptr_q + {{ASIZE{1'b0}}, r_acc};
        count_d     = count_q + {{ASIZE{1'b0}}, w_acc} - {{ASIZE{1'b0}}, r_acc};
        wfull_d     = (count_d == DEPTH_C);
        awfull_d    = (count_d >= AFULL_TH);
        rempty_d    = (count_d == '0);
        arempty_d   = (count_d <= AEMPTY_TH);
        overflow_d  = winc & wfull_q;
        underflow_d = rinc & rempty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wfull_q     <= 1'b0;
            awfull_q    <= 1'b0;
            rempty_q    <= 1'b1;
            arempty_q   <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            wfull_q     <= wfull_d;
            awfull_q    <= awfull_d;
            rempty_q    <= rempty_d;
            arempty_q   <= arempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            mem[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    generate
        if (FALLTHROUGH == "TRUE") begin : g_fallthrough
            // Head of queue is always presented; meaningless while empty.
            assign rdata = mem[rptr_q[ASIZE-1:0]];
        end else begin : g_registered
            logic [DSIZE-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (r_acc) begin
                    rdata_d = mem[rptr_q[ASIZE-1:0]];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

    assign wfull     = wfull_q;
    assign awfull    = awfull_q;
    assign rempty    = rempty_q;
    assign arempty   = arempty_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: one fall-through and one registered-read instance
// share stimulus; a queue-based model predicts every output each cycle.

module tb_sync_fifo;

    localparam int DSIZE  = 8;
    localparam int ASIZE  = 4;
    localparam int DEPTH  = 16;
    localparam int ALMOST = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             winc = 1'b0;
    logic             rinc = 1'b0;
    logic [DSIZE-1:0] wdata = '0;

    logic             wfull_f, awfull_f, ovf_f, rempty_f, arempty_f, unf_f;
    logic [DSIZE-1:0] rdata_f;
    logic [ASIZE:0]   count_f;
    logic             wfull_r, awfull_r, ovf_r, rempty_r, arempty_r, unf_r;
    logic [DSIZE-1:0] rdata_r;
    logic [ASIZE:0]   count_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("TRUE"), .ALMOST(ALMOST)) u_ft (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull_f),
        .awfull(awfull_f), .overflow(ovf_f), .rinc(rinc), .rdata(rdata_f),
        .rempty(rempty_f), .arempty(arempty_f), .underflow(unf_f), .count(count_f)
    );

    sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("FALSE"), .ALMOST(ALMOST)) u_rg (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull_r),
        .awfull(awfull_r), .overflow(ovf_r), .rinc(rinc), .rdata(rdata_r),
        .rempty(rempty_r), .arempty(arempty_r), .underflow(unf_r), .count(count_r)
    );

    // Behavioural model: a queue plus the last popped word and the error pulses.
    logic [DSIZE-1:0] m_q[$];
    logic [DSIZE-1:0] m_rd_reg = '0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_rd_reg = '0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            m_ovf = winc && was_full;
            m_unf = rinc && was_empty;
            if (rinc && !was_empty) m_rd_reg = m_q.pop_front();
            if (winc && !was_full) m_q.push_back(wdata);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int n;
        n = m_q.size();
        chk("count_ft", int'(count_f), n);
        chk("count_rg", int'(count_r), n);
        chk("wfull_ft", int'(wfull_f), int'(n == DEPTH));
        chk("wfull_rg", int'(wfull_r), int'(n == DEPTH));
        chk("rempty_ft", int'(rempty_f), int'(n == 0));
        chk("rempty_rg", int'(rempty_r), int'(n == 0));
        chk("awfull_ft", int'(awfull_f), int'(n >= DEPTH - ALMOST));
        chk("awfull_rg", int'(awfull_r), int'(n >= DEPTH - ALMOST));
        chk("arempty_ft", int'(arempty_f), int'(n <= ALMOST));
        chk("arempty_rg", int'(arempty_r), int'(n <= ALMOST));
        chk("overflow_ft", int'(ovf_f), int'(m_ovf));
        chk("overflow_rg", int'(ovf_r), int'(m_ovf));
        chk("underflow_ft", int'(unf_f), int'(m_unf));
        chk("underflow_rg", int'(unf_r), int'(m_unf));
        chk("rdata_rg", int'(rdata_r), int'(m_rd_reg));
        if (n != 0) chk("rdata_ft", int'(rdata_f), int'(m_q[0]));
    end

    // Inputs change just after a falling edge and are held across the rising edge.
    task automatic step(input bit w, input bit r, input logic [DSIZE-1:0] d);
        winc  = w;
        rinc  = r;
        wdata = d;
        @(negedge clk);
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    initial begin
        #23;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        chk("rst_rempty", int'(rempty_f), 1);
        chk("rst_arempty", int'(arempty_f), 1);
        chk("rst_wfull", int'(wfull_f), 0);
        chk("rst_awfull", int'(awfull_f), 0);
        chk("rst_count", int'(count_f), 0);
        chk("rst_ovf_unf", int'({ovf_f, unf_f, ovf_r, unf_r}), 0);
        chk("rst_rdata_rg", int'(rdata_r), 0);
        step(0, 0, 8'h00);

        // Fill 0x00..0x0F, then a rejected 0xAA
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(i));
            chk("fill_count", int'(count_f), i + 1);
            chk("fill_awfull", int'(awfull_f), int'(i + 1 >= 14));
        end
        chk("fill_wfull", int'(wfull_f), 1);
        step(1, 0, 8'hAA);
        chk("fill_overflow", int'(ovf_f), 1);
        chk("fill_count16", int'(count_f), 16);
        step(0, 0, 8'h00);
        chk("fill_overflow_drop", int'(ovf_f), 0);

        // Drain: fall-through shows next word, registered shows popped word
        chk("drain_ft_first", int'(rdata_f), 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 8'h00);
            chk("drain_rg", int'(rdata_r), i);
            if (i < DEPTH - 1) chk("drain_ft", int'(rdata_f), i + 1);
            chk("drain_arempty", int'(arempty_f), int'(DEPTH - 1 - i <= 2));
            step(0, 0, 8'h00);
            chk("drain_rg_hold", int'(rdata_r), i);
        end
        chk("drain_rempty", int'(rempty_f), 1);
        step(0, 1, 8'h00);
        chk("drain_underflow", int'(unf_f), 1);
        chk("drain_count0", int'(count_f), 0);
        chk("drain_rg_hold_unf", int'(rdata_r), 8'h0F);

        // Simultaneous read and write at full and at empty
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom));
        step(1, 1, 8'h77);
        chk("sim_full_count", int'(count_f), 15);
        chk("sim_full_ovf", int'(ovf_f), 1);
        for (int i = 0; i < 15; i++) step(0, 1, 8'h00);
        step(1, 1, 8'h66);
        chk("sim_empty_count", int'(count_f), 1);
        chk("sim_empty_unf", int'(unf_f), 1);
        chk("sim_empty_ft_data", int'(rdata_f), 8'h66);

        // Streaming at count 5 across pointer wrap
        for (int i = 0; i < 4; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1, 1, 8'($urandom));
        chk("stream_count", int'(count_f), 5);

        // Randomized traffic with varying bias to reach full and empty
        for (int blk = 0; blk < 8; blk++) begin
            int wp;
            wp = (blk % 2 == 0) ? 80 : 20;
            for (int i = 0; i < 60; i++)
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 50, 8'($urandom));
        end

        // Reset in the middle of a cycle at count 9
        while (count_f > 0) step(0, 1, 8'h00);
        for (int i = 0; i < 9; i++) step(1, 0, 8'($urandom));
        chk("mid_count9", int'(count_f), 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", int'(count_f), 0);
        chk("mid_rst_rempty", int'(rempty_f), 1);
        chk("mid_rst_arempty", int'(arempty_f), 1);
        chk("mid_rst_awfull", int'(awfull_f), 0);
        chk("mid_rst_rdata_rg", int'(rdata_r), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 8'h55);
        chk("post_rst_ft", int'(rdata_f), 8'h55);
        step(0, 1, 8'h00);
        chk("post_rst_rg", int'(rdata_r), 8'h55);
        chk("post_rst_count", int'(count_f), 0);
        step(0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
